// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-lite arbiter (M0 = CPU, M1 = DMA) with data-phase owner tracking.
// Optional saturating stall counters when MFP_ARB_STATS_EN is defined.
module mfp_ahb_arbiter #(
  parameter int PARK_M0 = 1,
  parameter int CNT_W   = 16
) (
  input  logic        HCLK,
  input  logic        rstn,
  input  logic [31:0] m0_HADDR,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HSIZE,
  input  logic [2:0]  m0_HBURST,
  input  logic [3:0]  m0_HPROT,
  input  logic        m0_HMASTLOCK,
  input  logic [31:0] m0_HWDATA,
  output logic [31:0] m0_HRDATA,
  output logic        m0_HREADY,
  output logic        m0_HRESP,
  input  logic [31:0] m1_HADDR,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HSIZE,
  input  logic [2:0]  m1_HBURST,
  input  logic [3:0]  m1_HPROT,
  input  logic        m1_HMASTLOCK,
  input  logic [31:0] m1_HWDATA,
  output logic [31:0] m1_HRDATA,
  output logic        m1_HREADY,
  output logic        m1_HRESP,
  output logic [31:0] s_HADDR,
  output logic [1:0]  s_HTRANS,
  output logic        s_HWRITE,
  output logic [2:0]  s_HSIZE,
  output logic [2:0]  s_HBURST,
  output logic [3:0]  s_HPROT,
  output logic        s_HMASTLOCK,
  output logic [31:0] s_HWDATA,
  input  logic [31:0] s_HRDATA,
  input  logic        s_HREADY,
  input  logic        s_HRESP,
  output logic        s_HMASTER
`ifdef MFP_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stall0,
  output logic [CNT_W-1:0] stall1
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic gnt_q, gnt_d;
  logic dp_vld_q, dp_vld_d;
  logic dp_own_q, dp_own_d;

  logic req0, req1;
  logic own_idle, own_lock, other_req, own_free;

  assign req0 = m0_HTRANS[1];
  assign req1 = m1_HTRANS[1];

  // Address phase follows the current grant with no added latency.
  always_comb begin
    if (gnt_q) begin
      s_HADDR     = m1_HADDR;
      s_HTRANS    = m1_HTRANS;
      s_HWRITE    = m1_HWRITE;
      s_HSIZE     = m1_HSIZE;
      s_HBURST    = m1_HBURST;
      s_HPROT     = m1_HPROT;
      s_HMASTLOCK = m1_HMASTLOCK;
    end else begin
      s_HADDR     = m0_HADDR;
      s_HTRANS    = m0_HTRANS;
      s_HWRITE    = m0_HWRITE;
      s_HSIZE     = m0_HSIZE;
      s_HBURST    = m0_HBURST;
      s_HPROT     = m0_HPROT;
      s_HMASTLOCK = m0_HMASTLOCK;
    end
  end

  assign own_idle  = gnt_q ? (m1_HTRANS == 2'b00) : (m0_HTRANS == 2'b00);
  assign own_lock  = gnt_q ? m1_HMASTLOCK : m0_HMASTLOCK;
  assign other_req = gnt_q ? req0 : req1;
  assign own_free  = own_idle && !own_lock;

  // Parking only moves the bus when the owner is IDLE and unlocked, so BUSY never hands over.
  always_comb begin
    gnt_d    = gnt_q;
    dp_vld_d = dp_vld_q;
    dp_own_d = dp_own_q;
    if (s_HREADY) begin
      dp_vld_d = s_HTRANS[1];
      dp_own_d = gnt_q;
      if (own_free && other_req) begin
        gnt_d = ~gnt_q;
      end else if (own_free && (PARK_M0 != 0) && !m0_HMASTLOCK) begin
        gnt_d = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!rstn) begin
      gnt_q    <= 1'b0;
      dp_vld_q <= 1'b0;
      dp_own_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      dp_vld_q <= dp_vld_d;
      dp_own_q <= dp_own_d;
    end
  end

  assign s_HMASTER = gnt_q;
  assign s_HWDATA  = dp_own_q ? m1_HWDATA : m0_HWDATA;
  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign m0_HRESP  = (dp_vld_q && !dp_own_q) ? s_HRESP : 1'b0;
  assign m1_HRESP  = (dp_vld_q &&  dp_own_q) ? s_HRESP : 1'b0;
  assign m0_HREADY = (!gnt_q || (dp_vld_q && !dp_own_q)) ? s_HREADY : 1'b0;
  assign m1_HREADY = ( gnt_q || (dp_vld_q &&  dp_own_q)) ? s_HREADY : 1'b0;

`ifdef MFP_ARB_STATS_EN
  logic [CNT_W-1:0] stall0_q, stall0_d;
  logic [CNT_W-1:0] stall1_q, stall1_d;

  always_comb begin
    stall0_d = stall0_q;
    stall1_d = stall1_q;
    if (req0 && gnt_q && !(&stall0_q)) stall0_d = stall0_q + 1'b1;
    if (req1 && !gnt_q && !(&stall1_q)) stall1_d = stall1_q + 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (!rstn) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      stall0_q <= stall0_d;
      stall1_q <= stall1_d;
    end
  end

  assign stall0 = stall0_q;
  assign stall1 = stall1_q;
`endif

endmodule
